// File: rtl/ring_chk_pkg.sv
// Shared types and helpers for the ring-counter period checker.
// Feature macro used by the top: RING_PERIOD_CHECKER_ERRCNT_EN.
package ring_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_e;

    // Ceiling log2, never below 1 bit.
    function automatic int clog2w(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int win_lo(input int p, input int tol);
        return p - 1 - tol;
    endfunction

    function automatic int win_hi(input int p, input int tol);
        return p - 1 + tol;
    endfunction

endpackage

// File: rtl/ring_chk_edge.sv
// Pulse front end: registers the monitored pulse and emits a rise strobe
// plus a once-per-high-run strobe on the second consecutive high sample.
module ring_chk_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pulse_i,
    output logic rise_o,
    output logic wide_o
);

    logic pulse_q;
    logic wide_seen_q;

    assign rise_o = pulse_i & ~pulse_q;
    assign wide_o = pulse_i & pulse_q & ~wide_seen_q;

    // wide_seen_q re-arms only once the pulse has gone low again.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pulse_q     <= 1'b0;
            wide_seen_q <= 1'b0;
        end else begin
            pulse_q     <= pulse_i;
            wide_seen_q <= pulse_i & (wide_seen_q | wide_o);
        end
    end

endmodule

// File: rtl/ring_period_checker.sv
// Period/width monitor for a ring-counter timing pulse with lock indication.
// Define RING_PERIOD_CHECKER_ERRCNT_EN to add the saturating ERR_CNT output.
module ring_period_checker
    import ring_chk_pkg::*;
#(
    parameter int C_NUM_CYCLES = 255,
    parameter int C_TOL        = 0,
    parameter int C_LOCK_GOOD  = 2
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
    ,
    parameter int C_ERRCNT_W   = 8
`endif
) (
    input  logic CK,
    input  logic RST,
    input  logic EN,
    input  logic PULSE,
    output logic LOCKED,
    output logic ERR_EARLY,
    output logic ERR_LATE,
    output logic ERR_WIDE,
    output logic ERR
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
    ,
    output logic [C_ERRCNT_W-1:0] ERR_CNT
`endif
);

    localparam int CNT_W  = clog2w(C_NUM_CYCLES + C_TOL + 1);
    localparam int GOOD_W = clog2w(C_LOCK_GOOD + 1);
    localparam int WIN_LO = win_lo(C_NUM_CYCLES, C_TOL);
    localparam int WIN_HI = win_hi(C_NUM_CYCLES, C_TOL);

    localparam logic [CNT_W-1:0]  WIN_LO_C = CNT_W'(WIN_LO);
    localparam logic [CNT_W-1:0]  WIN_HI_C = CNT_W'(WIN_HI);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(C_LOCK_GOOD);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic               locked_q, locked_d;
    logic               early_q, early_d;
    logic               late_q, late_d;
    logic               wide_q, wide_d;
    logic               err_q;
    logic               rise;
    logic               wide;

    ring_chk_edge u_edge (
        .clk_i   (CK),
        .rst_i   (RST),
        .pulse_i (PULSE),
        .rise_o  (rise),
        .wide_o  (wide)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        early_d = 1'b0;
        late_d  = 1'b0;
        wide_d  = 1'b0;

        if (!EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    cnt_d   = '0;
                    good_d  = '0;
                end
                ST_ACQUIRE: begin
                    wide_d = wide;
                    if (rise) begin
                        cnt_d   = '0;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    wide_d = wide;
                    // A missing edge is replaced by a virtual one at the window end.
                    if (rise) begin
                        cnt_d = '0;
                        if (cnt_q < WIN_LO_C) begin
                            early_d = 1'b1;
                            good_d  = '0;
                        end else if (good_q != GOOD_MAX) begin
                            good_d = good_q + 1'b1;
                        end
                    end else if (cnt_q == WIN_HI_C) begin
                        late_d = 1'b1;
                        cnt_d  = '0;
                        good_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    good_d  = '0;
                end
            endcase
        end

        if (wide_d) begin
            good_d = '0;
        end
        locked_d = (good_d == GOOD_MAX);
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            wide_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            early_q  <= early_d;
            late_q   <= late_d;
            wide_q   <= wide_d;
            err_q    <= early_d | late_d | wide_d;
        end
    end

    assign LOCKED    = locked_q;
    assign ERR_EARLY = early_q;
    assign ERR_LATE  = late_q;
    assign ERR_WIDE  = wide_q;
    assign ERR       = err_q;

`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
    logic [C_ERRCNT_W-1:0] errcnt_q;

    // Counts error cycles, not individual flags; survives EN low.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            errcnt_q <= '0;
        end else if ((early_d | late_d | wide_d) && (errcnt_q != '1)) begin
            errcnt_q <= errcnt_q + 1'b1;
        end
    end

    assign ERR_CNT = errcnt_q;
`endif

endmodule

// File: tb/tb_ring_period_checker.sv
// Bench for ring_period_checker with P=8, C_TOL=0, C_LOCK_GOOD=2.
// Build with RING_PERIOD_CHECKER_ERRCNT_EN to also cover ERR_CNT.
module tb_ring_period_checker;

    localparam int P   = 8;
    localparam int TOL = 0;
    localparam int LG  = 2;

    localparam logic [4:0] F_EARLY = 5'b00100;
    localparam logic [4:0] F_LATE  = 5'b00010;
    localparam logic [4:0] F_WIDE  = 5'b00001;

    logic CK    = 1'b0;
    logic RST   = 1'b1;
    logic EN    = 1'b0;
    logic PULSE = 1'b0;
    logic LOCKED, ERR_EARLY, ERR_LATE, ERR_WIDE, ERR;
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
    logic [7:0] ERR_CNT;
`endif

    ring_period_checker #(
        .C_NUM_CYCLES (P),
        .C_TOL        (TOL),
        .C_LOCK_GOOD  (LG)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .EN        (EN),
        .PULSE     (PULSE),
        .LOCKED    (LOCKED),
        .ERR_EARLY (ERR_EARLY),
        .ERR_LATE  (ERR_LATE),
        .ERR_WIDE  (ERR_WIDE),
        .ERR       (ERR)
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
        ,
        .ERR_CNT   (ERR_CNT)
`endif
    );

    always #5 CK = ~CK;

    // exp bits: {locked, err, early, late, wide}, output seen after that cycle's edge
    typedef struct packed {
        logic       en;
        logic       pulse;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs [0:63];
    int         nvec;
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] exp_q [$];

    function automatic logic [4:0] actual_outs();
        return {LOCKED, ERR, ERR_EARLY, ERR_LATE, ERR_WIDE};
    endfunction

    task automatic clear_vecs(input int n);
        for (int i = 0; i < 64; i++) begin
            vecs[i] = '{en: 1'b1, pulse: 1'b0, exp: 5'b0};
        end
        nvec = n;
    endtask

    task automatic add_pulse(input int c, input int w);
        for (int k = 0; k < w; k++) begin
            vecs[c + k].pulse = 1'b1;
        end
    endtask

    task automatic add_flag(input int c, input logic [4:0] m);
        vecs[c].exp = vecs[c].exp | m | 5'b01000;
    endtask

    task automatic add_locked(input int a, input int b);
        for (int i = a; i < b; i++) begin
            vecs[i].exp[4] = 1'b1;
        end
    endtask

    task automatic check_outs(input string name, input int idx);
        logic [4:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s[%0d] scoreboard empty", name, idx);
        end else begin
            e = exp_q.pop_front();
            if (actual_outs() !== e) begin
                failures++;
                $display("FAIL %s[%0d] outs{locked,err,early,late,wide} got=%b exp=%b",
                         name, idx, actual_outs(), e);
            end
        end
    endtask

    task automatic run_vecs(input string name);
        for (int i = 0; i < nvec; i++) begin
            EN    = vecs[i].en;
            PULSE = vecs[i].pulse;
            exp_q.push_back(vecs[i].exp);
            @(posedge CK);
            @(negedge CK);
            check_outs(name, i);
        end
    endtask

    task automatic hold_reset();
        RST   = 1'b1;
        EN    = 1'b0;
        PULSE = 1'b0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
    endtask

    // Reset asserted between edges; outputs must drop before the next CK rise.
    task automatic async_reset_check(input string name);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (actual_outs() !== 5'b0) begin
            failures++;
            $display("FAIL %s outs got=%b exp=%b", name, actual_outs(), 5'b0);
        end
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
        checks++;
        if (ERR_CNT !== 8'd0) begin
            failures++;
            $display("FAIL %s err_cnt got=%0d exp=0", name, ERR_CNT);
        end
`endif
        hold_reset();
    endtask

    initial begin
        @(negedge CK);
        checks++;
        if (actual_outs() !== 5'b0) begin
            failures++;
            $display("FAIL reset_state outs got=%b exp=%b", actual_outs(), 5'b0);
        end
`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
        checks++;
        if (ERR_CNT !== 8'd0) begin
            failures++;
            $display("FAIL reset_errcnt got=%0d exp=0", ERR_CNT);
        end
`endif
        hold_reset();

        // Clean lock, then async reset while locked, then the same again.
        clear_vecs(40);
        add_pulse(10, 1); add_pulse(18, 1); add_pulse(26, 1); add_pulse(34, 1);
        add_locked(26, 40);
        run_vecs("s1_lock");
        async_reset_check("s5_rst_locked");
        run_vecs("s5_after_rst");

        hold_reset();
        clear_vecs(60);
        add_pulse(10, 1); add_pulse(18, 1); add_pulse(26, 1); add_pulse(32, 1);
        add_pulse(40, 1); add_pulse(48, 1); add_pulse(56, 1);
        add_flag(32, F_EARLY);
        add_locked(26, 32);
        add_locked(48, 60);
        run_vecs("s2_early");

        // Pulses stop; late repeats every P+TOL; reset while the flag is up.
        hold_reset();
        clear_vecs(51);
        add_pulse(10, 1); add_pulse(18, 1); add_pulse(26, 1);
        add_flag(34, F_LATE); add_flag(42, F_LATE); add_flag(50, F_LATE);
        add_locked(26, 34);
        run_vecs("s3_late");
        async_reset_check("s5_rst_flag");

        clear_vecs(56);
        add_pulse(10, 1); add_pulse(18, 1); add_pulse(26, 1);
        add_pulse(34, 3); add_pulse(42, 1); add_pulse(50, 1);
        add_flag(35, F_WIDE);
        add_locked(26, 35);
        add_locked(50, 56);
        run_vecs("s4_wide");

        // EN low where a late flag would fire: suppressed, lock lost, reacquire.
        hold_reset();
        clear_vecs(60);
        add_pulse(10, 1); add_pulse(18, 1); add_pulse(26, 1);
        add_pulse(38, 1); add_pulse(46, 1); add_pulse(54, 1);
        vecs[34].en = 1'b0;
        add_locked(26, 34);
        add_locked(54, 60);
        run_vecs("en_clear");

        // PULSE high at reset release must not be taken as the first edge.
        hold_reset();
        clear_vecs(30);
        add_pulse(0, 1); add_pulse(8, 1); add_pulse(16, 1); add_pulse(24, 1);
        add_locked(24, 30);
        run_vecs("rel_high");

`ifdef RING_PERIOD_CHECKER_ERRCNT_EN
        hold_reset();
        EN = 1'b1;
        for (int i = 0; i < 620; i++) begin
            PULSE = ((i % 2) == 0);
            @(posedge CK);
            @(negedge CK);
            if (i == 19) begin
                checks++;
                if (ERR_CNT !== 8'd8) begin
                    failures++;
                    $display("FAIL s6_errcnt_8 got=%0d exp=8", ERR_CNT);
                end
            end
        end
        checks++;
        if (ERR_CNT !== 8'd255) begin
            failures++;
            $display("FAIL s6_errcnt_sat got=%0d exp=255", ERR_CNT);
        end
        PULSE = 1'b0;
        EN    = 1'b0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        EN = 1'b1;
        repeat (3) @(posedge CK);
        @(negedge CK);
        checks++;
        if (ERR_CNT !== 8'd255) begin
            failures++;
            $display("FAIL s6_errcnt_en got=%0d exp=255", ERR_CNT);
        end
        async_reset_check("s6_errcnt_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
